// File: rtl/dbus_uncached_bridge.sv
// dbus_uncached_bridge: turns one CPU data-bus request into one single-beat
// cache-bus transaction, with a watchdog that ends a transaction the bus
// never answers. Used for uncached / MMIO accesses that bypass the D-cache.

package dbus_uncached_bridge_pkg;

  typedef logic [2:0] msize_t;
  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef logic [1:0] axi_burst_t;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module dbus_uncached_bridge
  import dbus_uncached_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      addr_q;
  msize_t           size_q;
  logic [7:0]       strobe_q;
  logic [63:0]      wdata_q;
  logic [63:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             watchdog_fire;

  // cnt_q holds the number of BUSY cycles already completed, so it equals
  // TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th BUSY cycle: that cycle is
  // the last one the bus gets before the transaction is forced to RESP.
  assign watchdog_fire = (TIMEOUT_CYCLES != 0) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  assign busy = (state_q != S_IDLE);

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Request latch, read-data capture, watchdog counter and error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dreq.valid) begin
            addr_q   <= dreq.addr;
            size_q   <= dreq.size;
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
            cnt_q    <= '0;
            err_q    <= 1'b0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A ready beat beats a simultaneous watchdog expiry.
          if (cresp.ready) begin
            rdata_q <= cresp.data;
          end else if (watchdog_fire) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
          end
        end
        S_RESP:  err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next-state and output decode; all outputs are functions of state only.
  // NOTE: every output and state_d gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    creq        = '0;
    dresp       = '0;
    timeout_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dreq.valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        creq.valid    = 1'b1;
        creq.is_write = |strobe_q;
        creq.size     = size_q;
        creq.addr     = addr_q;
        creq.strobe   = strobe_q;
        creq.data     = wdata_q;
        creq.len      = MLEN1;
        creq.burst    = AXI_BURST_FIXED;
        if (cresp.ready) begin
          if (cresp.last) state_d = S_RESP;
        end else if (watchdog_fire) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = rdata_q;
        timeout_err   = err_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Testbench for dbus_uncached_bridge: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the bridge.

module tb_dbus_uncached_bridge;
  import dbus_uncached_bridge_pkg::*;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       resetn;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_uncached_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .dreq(dreq),
    .dresp(dresp),
    .creq(creq),
    .cresp(cresp),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_active: a request has been taken and its bus transaction is open.
  // m_resp:   the response for the last transaction is due this cycle.
  // m_wait:   bus cycles spent so far on the open transaction.
  bit          m_active, m_resp, m_err;
  dbus_req_t   m_req;
  int          m_wait;
  logic [63:0] m_data;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_resp   <= 1'b0;
      m_err    <= 1'b0;
      m_req    <= '0;
      m_wait   <= 0;
      m_data   <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (!m_active) begin
      if (dreq.valid) begin
        m_active <= 1'b1;
        m_req    <= dreq;
        m_wait   <= 0;
        m_err    <= 1'b0;
      end
    end else begin
      m_wait <= m_wait + 1;
      if (cresp.ready) begin
        m_data <= cresp.data;
        if (cresp.last) begin
          m_active <= 1'b0;
          m_resp   <= 1'b1;
          m_err    <= 1'b0;
        end
      end else if (m_wait + 1 == TMO) begin
        m_data   <= '1;
        m_err    <= 1'b1;
        m_active <= 1'b0;
        m_resp   <= 1'b1;
      end
    end
  end

  function automatic cbus_req_t exp_creq();
    cbus_req_t r = '0;
    if (m_active) begin
      r.valid    = 1'b1;
      r.is_write = |m_req.strobe;
      r.size     = m_req.size;
      r.addr     = m_req.addr;
      r.strobe   = m_req.strobe;
      r.data     = m_req.data;
      r.len      = 8'd0;
      r.burst    = 2'b00;
    end
    return r;
  endfunction

  function automatic dbus_resp_t exp_dresp();
    dbus_resp_t r = '0;
    if (m_resp) begin
      r.addr_ok = 1'b1;
      r.data_ok = 1'b1;
      r.data    = m_data;
    end
    return r;
  endfunction

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("model_creq", creq, exp_creq());
    check("model_dresp", dresp, exp_dresp());
    check("model_busy", busy, m_active || m_resp);
    check("model_timeout_err", timeout_err, m_resp && m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic dbus_req_t mk_req(input logic [63:0] addr, input msize_t size,
                                       input logic [7:0] strobe, input logic [63:0] data);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.size   = size;
    r.strobe = strobe;
    r.data   = data;
    return r;
  endfunction

  function automatic cbus_resp_t mk_beat(input logic last, input logic [63:0] data);
    cbus_resp_t r;
    r.ready = 1'b1;
    r.last  = last;
    r.data  = data;
    return r;
  endfunction

  // Safety net: the run is a few thousand cycles; never hang.
  initial begin
    #200000;
    $display("FAIL sim_time_limit: simulation did not reach its end");
    $fatal(1, "time limit");
  end

  initial begin
    int ready_pct;
    resetn = 1'b0;
    dreq   = '0;
    cresp  = '0;
    tick();
    tick();
    check("reset_creq", creq, 151'd0);
    check("reset_dresp", dresp, 66'd0);
    check("reset_busy", busy, 1'b0);
    resetn = 1'b1;
    tick();

    // Read: single-beat with immediate ready+last, 3-cycle latency.
    dreq = mk_req(64'h1000_0008, MSIZE4, 8'h00, 64'h0);
    tick();
    dreq = '0;
    check("rd_creq_valid", creq.valid, 1'b1);
    check("rd_is_write", creq.is_write, 1'b0);
    check("rd_len", creq.len, 8'd0);
    check("rd_burst", creq.burst, 2'b00);
    check("rd_addr", creq.addr, 64'h1000_0008);
    check("rd_no_early_data_ok", dresp.data_ok, 1'b0);
    cresp = mk_beat(1'b1, 64'h1122_3344_5566_7788);
    tick();
    cresp = '0;
    check("rd_data_ok", dresp.data_ok, 1'b1);
    check("rd_addr_ok", dresp.addr_ok, 1'b1);
    check("rd_data", dresp.data, 64'h1122_3344_5566_7788);
    check("rd_terr", timeout_err, 1'b0);
    check("rd_resp_creq_valid", creq.valid, 1'b0);
    tick();
    check("rd_idle_busy", busy, 1'b0);
    check("rd_idle_data_ok", dresp.data_ok, 1'b0);

    // Write with three wait states.
    dreq = mk_req(64'h1000_0001, MSIZE1, 8'b0000_0010, 64'h0000_0000_0000_CD00);
    tick();
    dreq = '0;
    check("wr_is_write", creq.is_write, 1'b1);
    check("wr_strobe", creq.strobe, 8'h02);
    check("wr_data", creq.data, 64'hCD00);
    check("wr_size", creq.size, 3'd0);
    for (int i = 0; i < 3; i++) begin
      check("wr_wait_busy", busy, 1'b1);
      check("wr_wait_data_ok", dresp.data_ok, 1'b0);
      tick();
    end
    cresp = mk_beat(1'b1, 64'h0000_0000_0000_BEEF);
    check("wr_busy_at_ready", busy, 1'b1);
    tick();
    cresp = '0;
    check("wr_data_ok", dresp.data_ok, 1'b1);
    check("wr_resp_busy", busy, 1'b1);
    tick();
    check("wr_idle_busy", busy, 1'b0);

    // Timeout: no ready for TMO bus cycles.
    dreq = mk_req(64'h1FC0_0000, MSIZE4, 8'h00, 64'h0);
    tick();
    dreq = '0;
    for (int i = 1; i < TMO; i++) begin
      check("to_wait_data_ok", dresp.data_ok, 1'b0);
      tick();
    end
    check("to_last_busy_cycle", creq.valid, 1'b1);
    tick();
    check("to_data_ok", dresp.data_ok, 1'b1);
    check("to_terr", timeout_err, 1'b1);
    check("to_data", dresp.data, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("to_terr_cleared", timeout_err, 1'b0);
    check("to_idle_busy", busy, 1'b0);

    // Ready+last in the very cycle the watchdog would expire: ready wins.
    dreq = mk_req(64'h1FC0_0010, MSIZE4, 8'h00, 64'h0);
    tick();
    dreq = '0;
    for (int i = 1; i < TMO; i++) tick();
    cresp = mk_beat(1'b1, 64'h5A5A_0000_1234_5678);
    tick();
    cresp = '0;
    check("race_data_ok", dresp.data_ok, 1'b1);
    check("race_terr", timeout_err, 1'b0);
    check("race_data", dresp.data, 64'h5A5A_0000_1234_5678);
    tick();

    // Back-to-back reads.
    dreq = mk_req(64'h2000_0000, MSIZE8, 8'h00, 64'h0);
    tick();
    dreq = '0;
    cresp = mk_beat(1'b1, 64'hAAAA_0000_0000_0001);
    tick();
    cresp = '0;
    check("b2b_first_data", dresp.data, 64'hAAAA_0000_0000_0001);
    tick();
    check("b2b_gap_data_ok", dresp.data_ok, 1'b0);
    check("b2b_gap_valid", creq.valid, 1'b0);
    dreq = mk_req(64'h2000_0040, MSIZE8, 8'h00, 64'h0);
    tick();
    dreq = '0;
    check("b2b_second_valid", creq.valid, 1'b1);
    check("b2b_second_addr", creq.addr, 64'h2000_0040);
    check("b2b_no_dup_data_ok", dresp.data_ok, 1'b0);
    cresp = mk_beat(1'b1, 64'hBBBB_0000_0000_0002);
    tick();
    cresp = '0;
    check("b2b_second_data", dresp.data, 64'hBBBB_0000_0000_0002);
    tick();
    check("b2b_end_data_ok", dresp.data_ok, 1'b0);

    // Stray non-last beat followed by the real one.
    dreq = mk_req(64'h3000_0000, MSIZE4, 8'h00, 64'h0);
    tick();
    dreq = '0;
    cresp = mk_beat(1'b0, 64'hA);
    tick();
    check("stray_still_valid", creq.valid, 1'b1);
    check("stray_no_data_ok", dresp.data_ok, 1'b0);
    cresp = mk_beat(1'b1, 64'hB);
    tick();
    cresp = '0;
    check("stray_data_ok", dresp.data_ok, 1'b1);
    check("stray_data", dresp.data, 64'hB);
    tick();
    for (int i = 0; i < 3; i++) begin
      cresp = mk_beat(1'b1, {$urandom, $urandom});
      tick();
      check("idle_ready_creq", creq, 151'd0);
      check("idle_ready_dresp", dresp, 66'd0);
      check("idle_ready_busy", busy, 1'b0);
    end
    cresp = '0;

    // Asynchronous reset mid-transaction.
    dreq = mk_req(64'h4000_0000, MSIZE4, 8'h00, 64'h0);
    tick();
    dreq = '0;
    check("rst_pre_valid", creq.valid, 1'b1);
    resetn = 1'b0;
    #1;
    check("rst_async_valid", creq.valid, 1'b0);
    check("rst_async_dresp", dresp, 66'd0);
    check("rst_async_busy", busy, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    dreq = mk_req(64'h4000_0008, MSIZE4, 8'h00, 64'h0);
    tick();
    dreq = '0;
    check("rst_after_valid", creq.valid, 1'b1);
    cresp = mk_beat(1'b1, 64'hC0FF_EE00_0000_0003);
    tick();
    cresp = '0;
    check("rst_after_data", dresp.data, 64'hC0FF_EE00_0000_0003);
    tick();

    // Randomized traffic; slow phases provoke the watchdog.
    ready_pct = 30;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        case ($urandom_range(0, 3))
          0:       ready_pct = 3;
          1:       ready_pct = 30;
          2:       ready_pct = 70;
          default: ready_pct = 100;
        endcase
      end
      dreq.valid = ($urandom_range(0, 99) < 60);
      dreq.addr  = {$urandom, $urandom};
      dreq.size  = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
      end else begin
        dreq.strobe = 8'($urandom);
        dreq.data   = {$urandom, $urandom};
      end
      cresp.ready = ($urandom_range(0, 99) < ready_pct);
      cresp.last  = ($urandom_range(0, 3) != 0);
      cresp.data  = {$urandom, $urandom};
      tick();
    end
    dreq  = '0;
    cresp = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
